nco_voice_mixer: RTL and testbench

Time-multiplexed, parametrised NCO bank for the audio path. Holds `NUM_VOICES` phase accumulators, each with its own frequency control word and four per-waveform shift scalers. On each sample request it walks the voices through one shared set of waveform LUTs and accumulates a single scaled, mixed sample. It sits between the sample-rate tick generator and the audio output FIFO/DAC.

---
 rtl/nco_voice_mixer.sv | 167 ++++++++++++++++
 tb/tb_nco_voice_mixer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/nco_voice_mixer.sv
// Time-multiplexed NCO bank: NUM_VOICES phase accumulators share one set of sine/square/triangle/sawtooth LUTs.
// LUT contents come from the *_IMG parameters. Define NCO_MIX_SATURATE_EN to clamp the mix; otherwise it wraps.
module nco_voice_mixer #(
  parameter int unsigned NUM_VOICES     = 4,
  parameter int unsigned ACC_WIDTH      = 24,
  parameter int unsigned LUT_ADDR_WIDTH = 8,
  parameter int unsigned SAMPLE_WIDTH   = 20,
  parameter logic [(2**LUT_ADDR_WIDTH)*SAMPLE_WIDTH-1:0] SINE_IMG     = '0,
  parameter logic [(2**LUT_ADDR_WIDTH)*SAMPLE_WIDTH-1:0] SQUARE_IMG   = '0,
  parameter logic [(2**LUT_ADDR_WIDTH)*SAMPLE_WIDTH-1:0] TRIANGLE_IMG = '0,
  parameter logic [(2**LUT_ADDR_WIDTH)*SAMPLE_WIDTH-1:0] SAWTOOTH_IMG = '0,
  localparam int unsigned VOICE_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_we,
  input  logic [VOICE_W-1:0]      cfg_voice,
  input  logic [ACC_WIDTH-1:0]    cfg_fcw,
  input  logic [19:0]             cfg_shift,
  input  logic                    cfg_en,
  input  logic                    cfg_phase_clr,
  input  logic                    sample_req,
  output logic [SAMPLE_WIDTH-1:0] sum_out,
  output logic                    sum_valid,
  input  logic                    sum_ready,
  output logic                    busy,
  output logic                    overrun
);

  localparam int unsigned ACCW = SAMPLE_WIDTH + 2 + $clog2(NUM_VOICES);
  localparam logic [4:0] MUTE = 5'd31;
  localparam logic signed [ACCW-1:0] SAT_HI = ACCW'((64'd1 << (SAMPLE_WIDTH - 1)) - 64'd1);
  localparam logic signed [ACCW-1:0] SAT_LO = ~SAT_HI;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, HOLD} state_t;
  state_t state_q, state_d;

  logic [ACC_WIDTH-1:0]      phase [NUM_VOICES];
  logic [ACC_WIDTH-1:0]      fcw   [NUM_VOICES];
  logic [19:0]               shift [NUM_VOICES];
  logic [NUM_VOICES-1:0]     en;
  logic [VOICE_W-1:0]        v;
  logic                      last_voice;
  logic                      drain_cnt;
  logic [LUT_ADDR_WIDTH-1:0] rd_addr;
  logic                      s1_valid;
  logic                      s1_en;
  logic [SAMPLE_WIDTH-1:0]   s1_word [4];
  logic [19:0]               s1_shift;
  logic signed [ACCW-1:0]    acc;
  logic signed [ACCW-1:0]    mix;
  logic [SAMPLE_WIDTH-1:0]   reduced;

  function automatic logic signed [ACCW-1:0] scale(input logic [SAMPLE_WIDTH-1:0] word,
                                                   input logic [4:0] amt);
    logic signed [ACCW-1:0] ext;
    ext = ACCW'($signed(word));
    return (amt == MUTE) ? '0 : (ext >>> amt);
  endfunction

  assign last_voice = (v == VOICE_W'(NUM_VOICES - 1));
  assign rd_addr    = phase[v][ACC_WIDTH-1 -: LUT_ADDR_WIDTH];
  assign busy       = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sample_req) state_d = RUN;
      RUN:     if (last_voice) state_d = DRAIN;
      DRAIN:   if (drain_cnt) state_d = HOLD;
      HOLD:    if (sum_valid && sum_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A phase clear wins over the advance; an advance in the same cycle as a write uses the old fcw/en.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_VOICES; i++) begin
        phase[i] <= '0;
        fcw[i]   <= '0;
        shift[i] <= '1;
      end
      en <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_VOICES; i++) begin
        if (cfg_we && cfg_voice == VOICE_W'(i)) begin
          fcw[i]   <= cfg_fcw;
          shift[i] <= cfg_shift;
          en[i]    <= cfg_en;
        end
        if (cfg_we && cfg_voice == VOICE_W'(i) && cfg_phase_clr)
          phase[i] <= '0;
        else if (state_q == RUN && v == VOICE_W'(i) && en[i])
          phase[i] <= phase[i] + fcw[i];
      end
    end
  end

  always_comb begin
    mix = '0;
    if (s1_en)
      mix = scale(s1_word[0], s1_shift[19:15]) + scale(s1_word[1], s1_shift[14:10])
          + scale(s1_word[2], s1_shift[9:5])   + scale(s1_word[3], s1_shift[4:0]);
  end

  always_comb begin
`ifdef NCO_MIX_SATURATE_EN
    if (acc > SAT_HI)      reduced = SAT_HI[SAMPLE_WIDTH-1:0];
    else if (acc < SAT_LO) reduced = SAT_LO[SAMPLE_WIDTH-1:0];
    else                   reduced = acc[SAMPLE_WIDTH-1:0];
`else
    reduced = acc[SAMPLE_WIDTH-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v         <= '0;
      drain_cnt <= 1'b0;
      s1_valid  <= 1'b0;
      s1_en     <= 1'b0;
      s1_shift  <= '1;
      s1_word   <= '{default: '0};
      acc       <= '0;
      sum_out   <= '0;
      sum_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      s1_valid   <= (state_q == RUN);
      s1_en      <= en[v];
      s1_shift   <= shift[v];
      s1_word[0] <= SINE_IMG[rd_addr*SAMPLE_WIDTH +: SAMPLE_WIDTH];
      s1_word[1] <= SQUARE_IMG[rd_addr*SAMPLE_WIDTH +: SAMPLE_WIDTH];
      s1_word[2] <= TRIANGLE_IMG[rd_addr*SAMPLE_WIDTH +: SAMPLE_WIDTH];
      s1_word[3] <= SAWTOOTH_IMG[rd_addr*SAMPLE_WIDTH +: SAMPLE_WIDTH];
      if (s1_valid) acc <= acc + mix;
      case (state_q)
        IDLE: if (sample_req) begin
          v   <= '0;
          acc <= '0;
        end
        RUN: begin
          v         <= v + 1'b1;
          drain_cnt <= 1'b0;
        end
        DRAIN: drain_cnt <= 1'b1;
        HOLD: begin
          if (!sum_valid) begin
            sum_out   <= reduced;
            sum_valid <= 1'b1;
          end else if (sum_ready) begin
            sum_valid <= 1'b0;
          end
        end
        default: ;
      endcase
      if (sample_req && state_q != IDLE) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_nco_voice_mixer.sv
// Scoreboard bench for nco_voice_mixer: stimulus pushes expected samples and arrival cycles, a monitor pops on handshake.
module tb_nco_voice_mixer;

  localparam int unsigned NV = 4;
  localparam int unsigned AW = 24;
  localparam int unsigned LA = 8;
  localparam int unsigned SW = 20;
  localparam int unsigned DEPTH = 2**LA;

  function automatic logic [DEPTH*SW-1:0] img_ramp();
    logic [DEPTH*SW-1:0] r;
    r = '0;
    for (int i = 0; i < int'(DEPTH); i++) r[i*SW +: SW] = SW'(i);
    return r;
  endfunction

  function automatic logic [DEPTH*SW-1:0] img_const(input logic [SW-1:0] c);
    logic [DEPTH*SW-1:0] r;
    r = '0;
    for (int i = 0; i < int'(DEPTH); i++) r[i*SW +: SW] = c;
    return r;
  endfunction

  localparam logic [DEPTH*SW-1:0] SINE_L = img_ramp();
  localparam logic [DEPTH*SW-1:0] SQR_L  = img_const(20'h7FFFF);
  localparam logic [DEPTH*SW-1:0] TRI_L  = img_const(20'h00010);
  localparam logic [DEPTH*SW-1:0] SAW_L  = img_const(20'h80000);

`ifdef NCO_MIX_SATURATE_EN
  localparam logic [SW-1:0] EXP_SQ  = 20'h7FFFF;
  localparam logic [SW-1:0] EXP_SAW = 20'h80000;
`else
  localparam logic [SW-1:0] EXP_SQ  = 20'hFFFFC;
  localparam logic [SW-1:0] EXP_SAW = 20'h00000;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_we, cfg_en, cfg_phase_clr, sample_req, sum_ready;
  logic [1:0]    cfg_voice;
  logic [AW-1:0] cfg_fcw;
  logic [19:0]   cfg_shift;
  logic [SW-1:0] sum_out;
  logic          sum_valid, busy, overrun;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;
  logic [SW-1:0] exp_q[$];
  int unsigned   due_q[$];
  logic          valid_prev = 1'b0;

  nco_voice_mixer #(
    .NUM_VOICES(NV), .ACC_WIDTH(AW), .LUT_ADDR_WIDTH(LA), .SAMPLE_WIDTH(SW),
    .SINE_IMG(SINE_L), .SQUARE_IMG(SQR_L), .TRIANGLE_IMG(TRI_L), .SAWTOOTH_IMG(SAW_L)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_voice(cfg_voice), .cfg_fcw(cfg_fcw),
    .cfg_shift(cfg_shift), .cfg_en(cfg_en), .cfg_phase_clr(cfg_phase_clr),
    .sample_req(sample_req), .sum_out(sum_out), .sum_valid(sum_valid),
    .sum_ready(sum_ready), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: latency checked on the rising edge of sum_valid, data checked on each handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      valid_prev = 1'b0;
    end else begin
      if (sum_valid && !valid_prev) begin
        if (due_q.size() == 0) check("unexpected_valid", 32'd1, 32'd0);
        else check("latency", cyc, due_q[0]);
      end
      if (sum_valid && sum_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_sample", {12'd0, sum_out}, 32'd0);
        end else begin
          check("sum_out", {12'd0, sum_out}, {12'd0, exp_q.pop_front()});
          void'(due_q.pop_front());
        end
      end
      valid_prev = sum_valid;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [19:0] shf(input logic [4:0] si, input logic [4:0] sq,
                                      input logic [4:0] tr, input logic [4:0] sw);
    return {si, sq, tr, sw};
  endfunction

  task automatic cfg(input int unsigned voice, input logic [AW-1:0] f, input logic [19:0] s,
                     input logic e, input logic clr);
    cfg_we = 1'b1; cfg_voice = 2'(voice); cfg_fcw = f; cfg_shift = s;
    cfg_en = e; cfg_phase_clr = clr;
    step();
    cfg_we = 1'b0; cfg_phase_clr = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      step();
      if (!busy && !sum_valid) done = 1'b1;
    end
    if (!done) check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_req(input logic [SW-1:0] exp);
    sample_req = 1'b1;
    exp_q.push_back(exp);
    due_q.push_back(cyc + NV + 4);
    step();
    sample_req = 1'b0;
    wait_idle();
  endtask

  initial begin
    rst_n = 1'b0; cfg_we = 1'b0; cfg_voice = '0; cfg_fcw = '0; cfg_shift = '0;
    cfg_en = 1'b0; cfg_phase_clr = 1'b0; sample_req = 1'b0; sum_ready = 1'b1;
    repeat (3) step();
    check("rst_sum_out", {12'd0, sum_out}, 32'd0);
    check("rst_sum_valid", {31'd0, sum_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    rst_n = 1'b1;
    step();

    // Sine ramp, voice 0 only
    cfg(0, 24'h010000, shf(0, 31, 31, 31), 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) do_req(SW'(i));

    // Phase wrap
    cfg(0, 24'h800000, shf(0, 31, 31, 31), 1'b1, 1'b1);
    do_req(20'h00000); do_req(20'h00080); do_req(20'h00000); do_req(20'h00080);
    cfg(0, 24'hFFFFFF, shf(0, 31, 31, 31), 1'b1, 1'b1);
    do_req(20'h00000); do_req(20'h000FF); do_req(20'h000FF);

    // Negative scaling and mute
    cfg(0, 24'h0, shf(31, 31, 31, 4), 1'b1, 1'b1);
    do_req(20'hF8000);
    cfg(0, 24'h0, shf(31, 31, 1, 4), 1'b1, 1'b0);
    do_req(20'hF8008);
    cfg(0, 24'h0, shf(31, 31, 31, 31), 1'b1, 1'b0);
    do_req(20'h00000);

    // Disabled voice contributes nothing and holds its phase
    cfg(0, 24'h010000, shf(0, 31, 31, 31), 1'b1, 1'b1);
    do_req(20'h00000);
    cfg(0, 24'h010000, shf(0, 31, 31, 31), 1'b0, 1'b0);
    do_req(20'h00000);
    cfg(0, 24'h010000, shf(0, 31, 31, 31), 1'b1, 1'b0);
    do_req(20'h00001);

    // Four voices at full scale: overflow behaviour
    for (int unsigned k = 0; k < NV; k++) cfg(k, 24'h0, shf(31, 31, 31, 0), 1'b1, 1'b1);
    do_req(EXP_SAW);
    for (int unsigned k = 0; k < NV; k++) cfg(k, 24'h0, shf(31, 0, 31, 31), 1'b1, 1'b1);
    do_req(EXP_SQ);

    // Backpressure: output held, extra request dropped and flagged
    check("overrun_before", {31'd0, overrun}, 32'd0);
    sum_ready = 1'b0;
    sample_req = 1'b1;
    exp_q.push_back(EXP_SQ);
    due_q.push_back(cyc + NV + 4);
    step();
    sample_req = 1'b0;
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
        step();
        if (sum_valid) seen = 1'b1;
      end
      if (!seen) check("valid_timeout", 32'd0, 32'd1);
    end
    for (int i = 0; i < 10; i++) begin
      check("hold_valid", {31'd0, sum_valid}, 32'd1);
      check("hold_data", {12'd0, sum_out}, {12'd0, EXP_SQ});
      sample_req = (i == 3);
      step();
    end
    sample_req = 1'b0;
    check("overrun_set", {31'd0, overrun}, 32'd1);
    sum_ready = 1'b1;
    wait_idle();
    check("overrun_sticky", {31'd0, overrun}, 32'd1);

    // Reset during RUN aborts the sample
    sample_req = 1'b1;
    step();
    sample_req = 1'b0;
    step();
    check("run_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    step();
    check("midrst_sum_out", {12'd0, sum_out}, 32'd0);
    check("midrst_sum_valid", {31'd0, sum_valid}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_overrun", {31'd0, overrun}, 32'd0);
    rst_n = 1'b1;
    step();
    cfg(0, 24'h010000, shf(0, 31, 31, 31), 1'b1, 1'b0);
    do_req(20'h00000);
    do_req(20'h00001);

    repeat (4) step();
    check("queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
